ingress_distributor: RTL and testbench

Ingress-side writer for the four-lane FIFO crossbar: accepts a stream of 10-bit words over a valid/ready handshake and pushes each word into one of the four input FIFOs (F0–F3) that the round-robin arbiter drains. The destination FIFO is decoded from the word's class field. Per-FIFO `almost_full` is honoured, so no FIFO is ever written once it reports almost full. Words are dispatched strictly in arrival order, with a 2-entry skid buffer decoupling upstream from FIFO backpressure.

---
 rtl/ingress_distributor.sv | 128 ++++++++++++
 tb/tb_ingress_distributor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ingress_distributor.sv
// Ingress writer for the four-lane FIFO crossbar: a 2-entry in-order skid queue
// feeding registered push strobes to F0..F3, routed by the word's class field.
module ingress_distributor #(
    parameter int DATA_W    = 10,
    parameter int CLASS_LSB = 8,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              almost_full_F0,
    input  logic              almost_full_F1,
    input  logic              almost_full_F2,
    input  logic              almost_full_F3,
    output logic              push_F0,
    output logic              push_F1,
    output logic              push_F2,
    output logic              push_F3,
    output logic [DATA_W-1:0] out_FIFO_0,
    output logic [DATA_W-1:0] out_FIFO_1,
    output logic [DATA_W-1:0] out_FIFO_2,
    output logic [DATA_W-1:0] out_FIFO_3,
    output logic [CNT_W-1:0]  push_count_0,
    output logic [CNT_W-1:0]  push_count_1,
    output logic [CNT_W-1:0]  push_count_2,
    output logic [CNT_W-1:0]  push_count_3,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SEND    = 2'b01,
        ST_BLOCKED = 2'b10
    } state_e;

    // Entry 0 is always the head; entry 1 shifts down on dequeue.
    logic [DATA_W-1:0] data_q [2];
    logic [DATA_W-1:0] data_d [2];
    logic [1:0]        cls_q  [2];
    logic [1:0]        cls_d  [2];
    logic [1:0]        occ_q, occ_d, occ_pop;
    state_e            state_q, state_d;
    logic [3:0]        push_q, push_d;
    logic [DATA_W-1:0] out_q [4];
    logic [DATA_W-1:0] out_d [4];
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  cnt_d [4];
    logic [3:0]        af;
    logic              accept, dispatch;

    assign af       = {almost_full_F3, almost_full_F2, almost_full_F1, almost_full_F0};
    assign in_ready = (occ_q != 2'd2);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        data_d   = data_q;
        cls_d    = cls_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        push_d   = '0;
        occ_pop  = occ_q;
        accept   = in_valid && (occ_q != 2'd2);
        dispatch = (occ_q != 2'd0) && !af[cls_q[0]];

        if (dispatch) begin
            push_d[cls_q[0]] = 1'b1;
            out_d[cls_q[0]]  = data_q[0];
            cnt_d[cls_q[0]]  = cnt_q[cls_q[0]] + 1'b1;
            data_d[0]        = data_q[1];
            cls_d[0]         = cls_q[1];
            occ_pop          = occ_q - 2'd1;
        end

        occ_d = occ_pop;
        if (accept) begin
            data_d[occ_pop[0]] = in_data;
            cls_d[occ_pop[0]]  = in_data[CLASS_LSB +: 2];
            occ_d              = occ_pop + 2'd1;
        end

        // State reflects the post-edge head against the almost_full seen at this edge.
        if (occ_d == 2'd0)        state_d = ST_IDLE;
        else if (af[cls_d[0]])    state_d = ST_BLOCKED;
        else                      state_d = ST_SEND;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q   <= 2'd0;
            state_q <= ST_IDLE;
            push_q  <= '0;
            for (int k = 0; k < 4; k++) begin
                out_q[k] <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            occ_q   <= occ_d;
            state_q <= state_d;
            push_q  <= push_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: queue storage is not reset; occupancy alone decides which entries are valid.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        cls_q  <= cls_d;
    end

    assign push_F0      = push_q[0];
    assign push_F1      = push_q[1];
    assign push_F2      = push_q[2];
    assign push_F3      = push_q[3];
    assign out_FIFO_0   = out_q[0];
    assign out_FIFO_1   = out_q[1];
    assign out_FIFO_2   = out_q[2];
    assign out_FIFO_3   = out_q[3];
    assign push_count_0 = cnt_q[0];
    assign push_count_1 = cnt_q[1];
    assign push_count_2 = cnt_q[2];
    assign push_count_3 = cnt_q[3];
    assign state        = state_q;

endmodule

// File: tb/tb_ingress_distributor.sv
// Directed bench for ingress_distributor, plus a per-FIFO order scoreboard
// for the random accept/dispatch overlap phase.
module tb_ingress_distributor;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [9:0] in_data;
    logic       in_ready;
    logic       almost_full_F0, almost_full_F1, almost_full_F2, almost_full_F3;
    logic       push_F0, push_F1, push_F2, push_F3;
    logic [9:0] out_FIFO_0, out_FIFO_1, out_FIFO_2, out_FIFO_3;
    logic [7:0] push_count_0, push_count_1, push_count_2, push_count_3;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    ingress_distributor dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .almost_full_F0 (almost_full_F0),
        .almost_full_F1 (almost_full_F1),
        .almost_full_F2 (almost_full_F2),
        .almost_full_F3 (almost_full_F3),
        .push_F0        (push_F0),
        .push_F1        (push_F1),
        .push_F2        (push_F2),
        .push_F3        (push_F3),
        .out_FIFO_0     (out_FIFO_0),
        .out_FIFO_1     (out_FIFO_1),
        .out_FIFO_2     (out_FIFO_2),
        .out_FIFO_3     (out_FIFO_3),
        .push_count_0   (push_count_0),
        .push_count_1   (push_count_1),
        .push_count_2   (push_count_2),
        .push_count_3   (push_count_3),
        .state          (state)
    );

    always #5 clk = ~clk;

    logic [3:0] push_vec;
    logic [9:0] outs [4];
    logic [7:0] cnts [4];
    assign push_vec = {push_F3, push_F2, push_F1, push_F0};
    assign outs[0] = out_FIFO_0;
    assign outs[1] = out_FIFO_1;
    assign outs[2] = out_FIFO_2;
    assign outs[3] = out_FIFO_3;
    assign cnts[0] = push_count_0;
    assign cnts[1] = push_count_1;
    assign cnts[2] = push_count_2;
    assign cnts[3] = push_count_3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_af(input logic [3:0] v);
        {almost_full_F3, almost_full_F2, almost_full_F1, almost_full_F0} = v;
    endtask

    // Scoreboard: expected words per FIFO, filled at accept edges, drained by pushes.
    logic       sb_en = 1'b0;
    logic [9:0] exp_q [4][$];
    logic [3:0] af_edge;

    always @(posedge clk) begin
        af_edge <= {almost_full_F3, almost_full_F2, almost_full_F1, almost_full_F0};
        if (sb_en && in_valid && in_ready)
            exp_q[in_data[9:8]].push_back(in_data);
    end

    always @(negedge clk) begin
        if (sb_en) begin
            check("sb_onehot", 32'($countones(push_vec) <= 1), 32'd1);
            for (int k = 0; k < 4; k++) begin
                if (push_vec[k]) begin
                    check("sb_af_at_edge", 32'(af_edge[k]), 32'd0);
                    if (exp_q[k].size() == 0) begin
                        check("sb_extra_push", 32'd1, 32'd0);
                    end else begin
                        check("sb_order", 32'(outs[k]), 32'(exp_q[k].pop_front()));
                    end
                end
            end
        end
    end

    logic [9:0] words [4];

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        set_af(4'b0000);
        tick();
        tick();
        reset = 1'b0;
        check("rst_push", 32'(push_vec), 32'h0);
        check("rst_out0", 32'(out_FIFO_0), 32'h0);
        check("rst_cnt3", 32'(push_count_3), 32'h0);
        check("rst_state", 32'(state), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h1);

        // Class routing: one push per FIFO, two edges after each accept.
        words[0] = 10'h005; words[1] = 10'h10A; words[2] = 10'h20F; words[3] = 10'h3FF;
        in_valid = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) in_data = words[i];
            else       in_valid = 1'b0;
            tick();
            if (i == 0) begin
                check("route_first_nopush", 32'(push_vec), 32'h0);
                check("route_state_send", 32'(state), 32'h1);
            end else begin
                check("route_push", 32'(push_vec), 32'(4'b0001 << (i - 1)));
                check("route_data", 32'(outs[i-1]), 32'(words[i-1]));
                check("route_ready", 32'(in_ready), 32'h1);
            end
        end
        tick();
        check("route_idle_push", 32'(push_vec), 32'h0);
        check("route_idle_state", 32'(state), 32'h0);
        for (int k = 0; k < 4; k++) check("route_cnt", 32'(cnts[k]), 32'h1);

        // Head-of-line blocking on F1 holds back the younger F0 word.
        set_af(4'b0010);
        in_valid = 1'b1;
        in_data  = 10'h101;
        tick();
        check("hol_state_blk1", 32'(state), 32'h2);
        in_data = 10'h002;
        tick();
        in_valid = 1'b0;
        check("hol_nopush", 32'(push_vec), 32'h0);
        check("hol_state", 32'(state), 32'h2);
        check("hol_ready", 32'(in_ready), 32'h0);
        tick();
        check("hol_still_nopush", 32'(push_vec), 32'h0);
        check("hol_still_ready", 32'(in_ready), 32'h0);
        set_af(4'b0000);
        tick();
        check("hol_rel_push", 32'(push_vec), 32'h2);
        check("hol_rel_data", 32'(out_FIFO_1), 32'h101);
        check("hol_rel_ready", 32'(in_ready), 32'h1);
        check("hol_rel_state", 32'(state), 32'h1);
        tick();
        check("hol_f0_push", 32'(push_vec), 32'h1);
        check("hol_f0_data", 32'(out_FIFO_0), 32'h002);
        check("hol_f1_hold", 32'(out_FIFO_1), 32'h101);
        check("hol_idle", 32'(state), 32'h0);

        // almost_full on F2/F3 must not stall a class-0 stream.
        set_af(4'b1100);
        in_valid = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) in_data = 10'(10'h020 + i);
            else       in_valid = 1'b0;
            tick();
            if (i > 0) begin
                check("nt_push", 32'(push_vec), 32'h1);
                check("nt_data", 32'(out_FIFO_0), 32'(10'h020 + i - 1));
            end
        end
        tick();
        // 1 (routing) + 1 (0x002) + 8 streamed words
        check("nt_cnt0", 32'(push_count_0), 32'd10);
        set_af(4'b0000);

        // Reset mid-stream with two words queued behind a blocked head.
        set_af(4'b0001);
        in_valid = 1'b1;
        in_data  = 10'h0AA;
        tick();
        in_data = 10'h0BB;
        tick();
        check("rq_ready_full", 32'(in_ready), 32'h0);
        reset   = 1'b1;
        in_data = 10'h0CC;
        tick();
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        set_af(4'b0000);
        check("rq_push", 32'(push_vec), 32'h0);
        check("rq_out0", 32'(out_FIFO_0), 32'h0);
        check("rq_out1", 32'(out_FIFO_1), 32'h0);
        check("rq_cnt0", 32'(push_count_0), 32'h0);
        check("rq_cnt1", 32'(push_count_1), 32'h0);
        check("rq_state", 32'(state), 32'h0);
        check("rq_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rq_discarded", 32'(push_vec), 32'h0);
        end

        // Counter wrap: 257 class-3 pushes leave push_count_3 at 1.
        in_valid = 1'b1;
        for (int i = 0; i < 257; i++) begin
            in_data = 10'(10'h300 | (i % 251));
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("wrap_cnt3", 32'(push_count_3), 32'h1);
        check("wrap_last", 32'(out_FIFO_3), 32'h305);
        check("wrap_cnt0", 32'(push_count_0), 32'h0);

        // Random overlap of accept and dispatch with almost_full toggling.
        sb_en    = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            in_data = 10'($urandom_range(0, 1023));
            set_af({($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)});
            tick();
        end
        in_valid = 1'b0;
        set_af(4'b0000);
        for (int i = 0; i < 6; i++) tick();
        sb_en = 1'b0;
        for (int k = 0; k < 4; k++) check("sb_lost", 32'(exp_q[k].size()), 32'd0);
        check("sb_end_state", 32'(state), 32'h0);
        check("sb_end_ready", 32'(in_ready), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
